// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding valid/ack access, stalls the pipe until the bus completes.
// Lane alignment, sign/zero extension, bus timeout; define LSU_MISALIGN_TRAP_EN to trap misaligned ops.
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_op_valid,
   input  logic              i_op_load,
   input  logic              i_op_store,
   input  logic [2:0]        i_op_func3,
   input  logic [XLEN-1:0]   i_op_addr,
   input  logic [XLEN-1:0]   i_op_wdata,
   input  logic [4:0]        i_op_rd,
   output logic              o_stall,
   output logic              o_ld_valid,
   output logic [XLEN-1:0]   o_ld_data,
   output logic [4:0]        o_ld_rd,
   output logic              o_trap,
   output logic [1:0]        o_trap_cause,
   output logic [XLEN-1:0]   o_trap_addr,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [XLEN-1:0]   o_mem_addr,
   output logic [XLEN/8-1:0] o_mem_be,
   output logic [XLEN-1:0]   o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [XLEN-1:0]   i_mem_rdata
);
   localparam int NB    = XLEN / 8;
   localparam int OFFW  = $clog2(NB);
   localparam int BITW  = $clog2(XLEN);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t            r_state, w_next;
   logic [15:0]       r_cnt;
   logic [XLEN-1:0]   r_addr;
   logic [1:0]        r_lsz;
   logic [OFFW-1:0]   r_off;
   logic              r_uns;
   logic [4:0]        r_rd;
   logic              r_is_load;
   logic              r_mem_req, r_mem_we;
   logic [XLEN-1:0]   r_mem_addr, r_mem_wdata;
   logic [NB-1:0]     r_mem_be;
   logic              r_ld_valid;
   logic [XLEN-1:0]   r_ld_data;
   logic [4:0]        r_ld_rd;
   logic              r_trap;
   logic [1:0]        r_trap_cause;
   logic [XLEN-1:0]   r_trap_addr;

   logic              w_accept, w_timeout, w_mis_trap;
   logic [1:0]        w_lsz_in;
   logic [OFFW-1:0]   w_szmask_in, w_off_in;
   logic [NB-1:0]     w_bmask, w_be_in;
   logic [XLEN-1:0]   w_addr_al, w_wdata_sh;
   logic [XLEN-1:0]   w_rsh, w_lmask, w_ld;
   logic [6:0]        w_bits;
   logic [BITW-1:0]   w_sidx;
   logic              w_sbit;

   // Access size is clamped to the bus width, so D/WU/111 on a 32-bit core become full-word accesses.
   assign w_lsz_in    = (32'(i_op_func3[1:0]) > OFFW) ? 2'(OFFW) : i_op_func3[1:0];
   assign w_szmask_in = OFFW'((1 << w_lsz_in) - 1);
   assign w_off_in    = i_op_addr[OFFW-1:0] & ~w_szmask_in;
   assign w_bmask     = NB'((1 << (1 << w_lsz_in)) - 1);
   assign w_be_in     = w_bmask << w_off_in;
   assign w_addr_al   = {i_op_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
   assign w_wdata_sh  = i_op_wdata << {w_off_in, 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_mis_trap = |(i_op_addr[OFFW-1:0] & w_szmask_in);
`else
   assign w_mis_trap = 1'b0;
`endif

   assign w_accept  = (r_state == S_IDLE) & i_op_valid & (i_op_load ^ i_op_store);
   assign w_timeout = (r_state == S_REQ) & ~i_mem_ack & (r_cnt == TO_LAST);
   assign o_stall   = i_rst_n & (w_accept | (r_state == S_REQ));

   // A full-width access shifts the mask out entirely, leaving it all ones (no extension).
   assign w_rsh   = i_mem_rdata >> {r_off, 3'b000};
   assign w_bits  = 7'(8 << r_lsz);
   assign w_lmask = ~({XLEN{1'b1}} << w_bits);
   assign w_sidx  = BITW'(w_bits - 7'd1);
   assign w_sbit  = w_rsh[w_sidx];
   assign w_ld    = (w_rsh & w_lmask) | ((~r_uns & w_sbit) ? ~w_lmask : {XLEN{1'b0}});

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_mis_trap ? S_RESP : S_REQ;
         S_REQ:   if (i_mem_ack || w_timeout) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt        <= '0;
         r_addr       <= '0;
         r_lsz        <= '0;
         r_off        <= '0;
         r_uns        <= 1'b0;
         r_rd         <= '0;
         r_is_load    <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_be     <= '0;
         r_mem_wdata  <= '0;
         r_ld_valid   <= 1'b0;
         r_ld_data    <= '0;
         r_ld_rd      <= '0;
         r_trap       <= 1'b0;
         r_trap_cause <= '0;
         r_trap_addr  <= '0;
      end else begin
         r_ld_valid <= 1'b0;
         r_trap     <= 1'b0;
         if (w_accept) begin
            r_cnt       <= '0;
            r_addr      <= i_op_addr;
            r_lsz       <= w_lsz_in;
            r_off       <= w_off_in;
            r_uns       <= i_op_func3[2];
            r_rd        <= i_op_rd;
            r_is_load   <= i_op_load;
            r_mem_req   <= ~w_mis_trap;
            r_mem_we    <= i_op_store;
            r_mem_addr  <= w_addr_al;
            r_mem_be    <= w_be_in;
            r_mem_wdata <= w_wdata_sh;
            if (w_mis_trap) begin
               r_trap       <= 1'b1;
               r_trap_cause <= i_op_load ? 2'b01 : 2'b10;
               r_trap_addr  <= i_op_addr;
            end
         end
         if (r_state == S_REQ) begin
            if (i_mem_ack) begin
               r_mem_req <= 1'b0;
               if (r_is_load) begin
                  r_ld_valid <= 1'b1;
                  r_ld_data  <= w_ld;
                  r_ld_rd    <= r_rd;
               end
            end else if (w_timeout) begin
               r_mem_req    <= 1'b0;
               r_trap       <= 1'b1;
               r_trap_cause <= 2'b11;
               r_trap_addr  <= r_addr;
            end else begin
               r_cnt <= r_cnt + 16'd1;
            end
         end
      end
   end

   assign o_ld_valid   = r_ld_valid;
   assign o_ld_data    = r_ld_data;
   assign o_ld_rd      = r_ld_rd;
   assign o_trap       = r_trap;
   assign o_trap_cause = r_trap_cause;
   assign o_trap_addr  = r_trap_addr;
   assign o_mem_req    = r_mem_req;
   assign o_mem_we     = r_mem_we;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_be     = r_mem_be;
   assign o_mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, random ops against a byte-level model, hand-written corner sequences.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_valid, op_load, op_store;
   logic [2:0]  op_func3;
   logic [31:0] op_addr, op_wdata;
   logic [4:0]  op_rd;
   logic        stall, ld_valid, trap, mem_req, mem_we, mem_ack;
   logic [31:0] ld_data, trap_addr, mem_addr, mem_wdata, mem_rdata;
   logic [4:0]  ld_rd;
   logic [1:0]  trap_cause;
   logic [3:0]  mem_be;

   logic        v64, ld64, st64, stall64, ldv64, trap64, req64, we64, ack64;
   logic [2:0]  f364;
   logic [63:0] addr64, wd64, ldd64, taddr64, maddr64, mwd64, rdata64;
   logic [4:0]  rd64, ldrd64;
   logic [1:0]  cause64;
   logic [7:0]  be64;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32), .TIMEOUT(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid), .i_op_load(op_load), .i_op_store(op_store),
      .i_op_func3(op_func3), .i_op_addr(op_addr), .i_op_wdata(op_wdata), .i_op_rd(op_rd),
      .o_stall(stall), .o_ld_valid(ld_valid), .o_ld_data(ld_data), .o_ld_rd(ld_rd), .o_trap(trap),
      .o_trap_cause(trap_cause), .o_trap_addr(trap_addr), .o_mem_req(mem_req), .o_mem_we(mem_we),
      .o_mem_addr(mem_addr), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack),
      .i_mem_rdata(mem_rdata));

   load_store_unit #(.XLEN(64), .TIMEOUT(4)) u64 (
      .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(v64), .i_op_load(ld64), .i_op_store(st64),
      .i_op_func3(f364), .i_op_addr(addr64), .i_op_wdata(wd64), .i_op_rd(rd64),
      .o_stall(stall64), .o_ld_valid(ldv64), .o_ld_data(ldd64), .o_ld_rd(ldrd64), .o_trap(trap64),
      .o_trap_cause(cause64), .o_trap_addr(taddr64), .o_mem_req(req64), .o_mem_we(we64),
      .o_mem_addr(maddr64), .o_mem_be(be64), .o_mem_wdata(mwd64), .i_mem_ack(ack64),
      .i_mem_rdata(rdata64));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Reference model for the 32-bit unit, expressed byte by byte.
   function automatic int msize(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int moff(input logic [2:0] f3, input logic [31:0] addr);
      int o = int'(addr % 4);
      return o - (o % msize(f3));
   endfunction

   function automatic bit mmis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
      return (addr % msize(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] mbe(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] b = '0;
      for (int i = 0; i < msize(f3); i++) b[moff(f3, addr) + i] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] mwd(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] r = '0;
      for (int i = 0; i < msize(f3); i++) r[8*(moff(f3, addr)+i) +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
      logic [31:0] r = '0;
      int sz = msize(f3);
      for (int i = 0; i < sz; i++) r[8*i +: 8] = rd[8*(moff(f3, addr)+i) +: 8];
      if (f3[2] == 1'b0 && sz < 4 && r[8*sz-1]) for (int i = 8*sz; i < 32; i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic run_op(input string tag, input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int k, input logic [31:0] rdata, input logic [4:0] rd,
                         input bit etrap, input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld);
      @(posedge clk); #1;
      op_valid = 1'b1; op_load = ld; op_store = !ld; op_func3 = f3;
      op_addr = addr; op_wdata = wd; op_rd = rd;
      if (etrap) begin
         @(negedge clk);
         chk({tag, "/mis_stall0"}, stall, 1);
         @(negedge clk);
         chk({tag, "/mis_trap"}, trap, 1);
         chk({tag, "/mis_cause"}, trap_cause, ld ? 2'b01 : 2'b10);
         chk({tag, "/mis_taddr"}, trap_addr, addr);
         chk({tag, "/mis_noreq"}, mem_req, 0);
         chk({tag, "/mis_stall1"}, stall, 0);
         chk({tag, "/mis_noldv"}, ld_valid, 0);
      end else begin
         for (int c = 0; c <= k + 1; c++) begin
            @(negedge clk);
            chk({tag, "/stall"}, stall, (c <= k) ? 1 : 0);
            chk({tag, "/req"}, mem_req, (c >= 1 && c <= k) ? 1 : 0);
            if (c >= 1 && c <= k) begin
               chk({tag, "/addr"}, mem_addr, addr & 32'hFFFF_FFFC);
               chk({tag, "/be"}, mem_be, ebe);
               chk({tag, "/we"}, mem_we, !ld);
               if (!ld) chk({tag, "/wdata"}, mem_wdata, ewd);
            end
            if (c == k + 1) begin
               chk({tag, "/ldv"}, ld_valid, ld);
               chk({tag, "/notrap"}, trap, 0);
               if (ld) begin
                  chk({tag, "/ldata"}, ld_data, eld);
                  chk({tag, "/ldrd"}, ld_rd, rd);
               end
            end else begin
               chk({tag, "/ldv_idle"}, ld_valid, 0);
            end
            mem_ack   = (c == k);
            mem_rdata = (c == k) ? rdata : $urandom;
         end
      end
      op_valid = 1'b0;
      mem_ack  = 1'b0;
   endtask

   task automatic run64(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] rdata, input logic [7:0] ebe, input logic [63:0] eld);
      @(posedge clk); #1;
      v64 = 1'b1; ld64 = 1'b1; st64 = 1'b0; f364 = f3; addr64 = addr; rd64 = 5'd9;
      @(negedge clk);
      chk({tag, "/stall"}, stall64, 1);
      @(negedge clk);
      chk({tag, "/req"}, req64, 1);
      chk({tag, "/addr"}, maddr64, addr & ~64'h7);
      chk({tag, "/be"}, be64, ebe);
      ack64 = 1'b1; rdata64 = rdata;
      @(negedge clk);
      ack64 = 1'b0;
      chk({tag, "/ldv"}, ldv64, 1);
      chk({tag, "/ldata"}, ldd64, eld);
      chk({tag, "/stall_end"}, stall64, 0);
      v64 = 1'b0;
   endtask

   typedef struct {
      string       tag;
      bit          ld;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rdata;
      int          k;
      bit          etrap;
      logic [3:0]  ebe;
      logic [31:0] ewd, eld;
   } vec_t;

   vec_t vt[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nreq;
      rst_n = 1'b0; op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_func3 = 3'b010;
      op_addr = 32'h100; op_wdata = '0; op_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
      v64 = 1'b0; ld64 = 1'b0; st64 = 1'b0; f364 = '0; addr64 = '0; wd64 = '0; rd64 = '0;
      ack64 = 1'b0; rdata64 = '0;

      @(negedge clk); @(negedge clk);
      chk("rst/stall", stall, 0);
      chk("rst/req", mem_req, 0);
      chk("rst/ldv", ld_valid, 0);
      chk("rst/ldata", ld_data, 0);
      chk("rst/trap", trap, 0);
      chk("rst/cause", trap_cause, 0);
      chk("rst/be", mem_be, 0);
      op_valid = 1'b0;
      rst_n = 1'b1;

      vt.push_back('{"lw",    1, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 0, 4'hF, 32'h0,        32'hDEADBEEF});
      vt.push_back('{"lb",    1, 3'b000, 32'h103, 32'h0,        32'h80000000, 1, 0, 4'h8, 32'h0,        32'hFFFFFF80});
      vt.push_back('{"lbu",   1, 3'b100, 32'h103, 32'h0,        32'h80000000, 1, 0, 4'h8, 32'h0,        32'h00000080});
      vt.push_back('{"sh",    0, 3'b001, 32'h102, 32'h1234,     32'h0,        1, 0, 4'hC, 32'h12340000, 32'h0});
      vt.push_back('{"lh",    1, 3'b001, 32'h102, 32'h0,        32'hABCD0000, 2, 0, 4'hC, 32'h0,        32'hFFFFABCD});
      vt.push_back('{"lhu",   1, 3'b101, 32'h102, 32'h0,        32'hABCD0000, 2, 0, 4'hC, 32'h0,        32'h0000ABCD});
      vt.push_back('{"sb",    0, 3'b000, 32'h101, 32'hA5,       32'h0,        1, 0, 4'h2, 32'h0000A500, 32'h0});
      vt.push_back('{"lw_ackexp", 1, 3'b010, 32'h300, 32'h0,    32'h5A5A5A5A, 4, 0, 4'hF, 32'h0,        32'h5A5A5A5A});
      vt.push_back('{"lwu32", 1, 3'b110, 32'h104, 32'h0,        32'h87654321, 1, 0, 4'hF, 32'h0,        32'h87654321});
`ifdef LSU_MISALIGN_TRAP_EN
      vt.push_back('{"lw_mis", 1, 3'b010, 32'h101, 32'h0,       32'h11223344, 1, 1, 4'h0, 32'h0,        32'h0});
      vt.push_back('{"sw_mis", 0, 3'b010, 32'h0FE, 32'hCAFEF00D, 32'h0,       2, 1, 4'h0, 32'h0,        32'h0});
      vt.push_back('{"lh_mis", 1, 3'b001, 32'h103, 32'h0,       32'h7FFF0000, 1, 1, 4'h0, 32'h0,        32'h0});
`else
      vt.push_back('{"lw_mis", 1, 3'b010, 32'h101, 32'h0,       32'h11223344, 1, 0, 4'hF, 32'h0,        32'h11223344});
      vt.push_back('{"sw_mis", 0, 3'b010, 32'h0FE, 32'hCAFEF00D, 32'h0,       2, 0, 4'hF, 32'hCAFEF00D, 32'h0});
      vt.push_back('{"lh_mis", 1, 3'b001, 32'h103, 32'h0,       32'h7FFF0000, 1, 0, 4'hC, 32'h0,        32'h00007FFF});
`endif
      for (int i = 0; i < vt.size(); i++)
         run_op(vt[i].tag, vt[i].ld, vt[i].f3, vt[i].addr, vt[i].wd, vt[i].k, vt[i].rdata, 5'(i + 1),
                vt[i].etrap, vt[i].ebe, vt[i].ewd, vt[i].eld);

      for (int i = 0; i < 40; i++) begin
         bit          rl = 1'($urandom % 2);
         logic [2:0]  rf = rl ? 3'($urandom % 8) : 3'($urandom % 3);
         logic [31:0] ra = $urandom, rw = $urandom, rr = $urandom;
         int          rk = 1 + int'($urandom % 3);
         run_op("rand", rl, rf, ra, rw, rk, rr, 5'($urandom), mmis(rf, ra),
                mbe(rf, ra), mwd(rf, ra, rw), mld(rf, ra, rr));
      end

      // Bus timeout: exactly TIMEOUT request cycles, then a trap; a late ack is ignored.
      @(posedge clk); #1;
      op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_func3 = 3'b010; op_addr = 32'h200; op_rd = 5'd7;
      nreq = 0;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         if (mem_req) nreq++;
         if (c <= 4) chk("to/stall", stall, 1);
         if (c == 5) begin
            chk("to/trap", trap, 1);
            chk("to/cause", trap_cause, 2'b11);
            chk("to/taddr", trap_addr, 32'h200);
            chk("to/noldv", ld_valid, 0);
            chk("to/stall_end", stall, 0);
            op_valid = 1'b0;
         end
      end
      chk("to/req_cycles", nreq, 4);
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("to/late_ack_ldv", ld_valid, 0);
      chk("to/late_ack_stall", stall, 0);
      run_op("after_to", 1, 3'b010, 32'h204, 32'h0, 2, 32'h0BADF00D, 5'd3, 0, 4'hF, 32'h0, 32'h0BADF00D);

      // Both load and store set: ignored.
      @(posedge clk); #1;
      op_valid = 1'b1; op_load = 1'b1; op_store = 1'b1;
      @(negedge clk);
      chk("both/stall", stall, 0);
      @(negedge clk);
      chk("both/req", mem_req, 0);
      op_valid = 1'b0; op_store = 1'b0;

      // Reset in the middle of a request.
      @(posedge clk); #1;
      op_valid = 1'b1; op_load = 1'b1; op_func3 = 3'b010; op_addr = 32'h400;
      @(negedge clk); @(negedge clk);
      chk("rstmid/req_before", mem_req, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid/req", mem_req, 0);
      chk("rstmid/stall", stall, 0);
      op_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst", 0, 3'b010, 32'h408, 32'h600DCAFE, 1, 32'h0, 5'd4, 0, 4'hF, 32'h600DCAFE, 32'h0);

      run64("ld64",  3'b011, 64'h8, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF);
      run64("lw64",  3'b010, 64'hC, 64'h80000000_00000000, 8'hF0, 64'hFFFFFFFF_80000000);
      run64("lwu64", 3'b110, 64'hC, 64'h80000000_00000000, 8'hF0, 64'h00000000_80000000);
      run64("lh64",  3'b001, 64'hE, 64'h8001_0000_0000_0000, 8'hC0, 64'hFFFFFFFF_FFFF8001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
